uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core_if.sv | 21 ++
 rtl/uart_rx_core.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Read-side handshake bundle for uart_rx_core: the receiver (master) presents
// a head word with valid, the consumer (slave) accepts it with ready.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] uart_rd_data;
  logic                 uart_rd_valid;
  logic                 uart_rd_ready;

  modport master (
    output uart_rd_data,
    output uart_rd_valid,
    input  uart_rd_ready
  );

  modport slave (
    input  uart_rd_data,
    input  uart_rd_valid,
    output uart_rd_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with parity/framing checks and receive storage.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_core #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  input  logic [1:0]     uart_mode,
  uart_rx_core_if.master rd,
  output logic           rx_frame_err,
  output logic           rx_parity_err,
  output logic           rx_overrun,
  output logic           rx_busy
);

  localparam longint TICK_RATE = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam int     DIV       = int'((longint'(CLK_FREQ) + TICK_RATE / 2) / TICK_RATE);
  localparam int     DIV_W     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int     OS_W      = $clog2(OVERSAMPLE);
  localparam int     BIT_W     = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_core: clock divider below 2, clock too slow for baud rate");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_core: OVERSAMPLE must be even and within 8..16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_core: DATA_BITS must be within 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_core: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE     = 2'b00,
    MODE_EVEN     = 2'b01,
    MODE_ODD      = 2'b10,
    MODE_TWO_STOP = 2'b11
  } mode_t;

  state_t               state;
  mode_t                mode_q;
  logic                 rxd_m, rxd_s, rxd_q;
  logic                 fall;
  logic [DIV_W-1:0]     tick_cnt;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic                 os_last;
  logic                 sample;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 stop_cnt;
  logic                 push_req;
  logic [DATA_BITS-1:0] push_data;
  logic                 pop;
  logic                 full;
  logic                 push_ok;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
    end
  end

  assign fall = rxd_q & ~rxd_s;

  // Held at zero in IDLE so the first tick after a start edge lands DIV cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick    = (state != S_IDLE) && (tick_cnt == DIV_W'(DIV - 1));
  assign os_last = (state == S_START) ? (os_cnt == OS_W'(OVERSAMPLE / 2 - 1))
                                      : (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign sample  = tick & os_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= MODE_NONE;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      stop_cnt      <= 1'b0;
      push_req      <= 1'b0;
      push_data     <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      push_req      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;

      if (state == S_IDLE) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_last ? '0 : os_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            mode_q  <= mode_t'(uart_mode);
            rx_busy <= 1'b1;
          end
        end

        S_START: begin
          if (sample) begin
            if (rxd_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              par_err  <= 1'b0;
              stop_cnt <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (sample) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              state <= (mode_q == MODE_EVEN || mode_q == MODE_ODD) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (sample) begin
            // Even parity: the data bits plus the parity bit XOR to zero; odd: to one.
            par_err <= (^shreg) ^ rxd_s ^ (mode_q == MODE_ODD);
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (sample) begin
            if (!rxd_s) begin
              rx_frame_err  <= 1'b1;
              rx_parity_err <= par_err;
              state         <= S_BREAK;
            end else if (mode_q == MODE_TWO_STOP && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              rx_parity_err <= par_err;
              push_req      <= ~par_err;
              push_data     <= shreg;
              state         <= S_IDLE;
              rx_busy       <= 1'b0;
            end
          end
        end

        S_BREAK: begin
          if (rxd_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push into full storage still lands.
  assign pop        = rd.uart_rd_valid & rd.uart_rd_ready;
  assign push_ok    = push_req & (~full | pop);
  assign rx_overrun = push_req & full & ~pop;

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0]     count, occ, count_next;
  logic [DATA_BITS-1:0] head_q, head_next;
  logic                 head_valid;

  assign full = (count == CNT_W'(FIFO_DEPTH));

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no inferred latch).
  always_comb begin
    rd_next    = rd_ptr + PTR_W'(pop);
    occ        = count - CNT_W'(pop);
    count_next = occ + CNT_W'(push_ok);
    head_next  = head_q;
    if (occ != '0) begin
      head_next = mem[rd_next];
    end else if (push_ok) begin
      head_next = push_data;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers and count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_q     <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_q     <= head_next;
      head_valid <= (count_next != '0);
    end
  end

  assign rd.uart_rd_data  = head_q;
  assign rd.uart_rd_valid = head_valid;
`else
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_valid;

  assign full = hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (push_ok) begin
      hold_data  <= push_data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign rd.uart_rd_data  = hold_data;
  assign rd.uart_rd_valid = hold_valid;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected words, a
// negedge monitor pops and compares accepted words and counts flag pulses.
module tb_uart_rx_core;

  localparam int BIT_CYC   = 864;
  localparam int DATA_BITS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [1:0] uart_mode;
  logic       rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

  uart_rx_core_if #(.DATA_BITS(DATA_BITS)) rd_if ();

  uart_rx_core #(
    .CLK_FREQ   (100000000),
    .BAUD_RATE  (115200),
    .OVERSAMPLE (16),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rxd      (uart_rxd),
    .uart_mode     (uart_mode),
    .rd            (rd_if),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int word_cnt = 0, frame_cnt = 0, par_cnt = 0, ovr_cnt = 0;
  int base_w   = 0, base_f = 0, base_p = 0, base_o = 0;
  logic [DATA_BITS-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: accepted words against the scoreboard, plus per-cycle flag counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_err)  frame_cnt++;
      if (rx_parity_err) par_cnt++;
      if (rx_overrun)    ovr_cnt++;
      if (rd_if.uart_rd_valid && rd_if.uart_rd_ready) begin
        word_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_word: got 0x%0h expected no word", rd_if.uart_rd_data);
        end else begin
          check("rd_data", 32'(rd_if.uart_rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                            input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    for (int i = 0; i < nstop; i++) send_bit(1'b1);
  endtask

  task automatic check_scenario(input string tag, input int w, input int f, input int p,
                                input int o);
    check({tag, "_words"},     32'(word_cnt - base_w),  32'(w));
    check({tag, "_frame_err"}, 32'(frame_cnt - base_f), 32'(f));
    check({tag, "_par_err"},   32'(par_cnt - base_p),   32'(p));
    check({tag, "_overrun"},   32'(ovr_cnt - base_o),   32'(o));
    check({tag, "_pending"},   32'(exp_q.size()),       32'd0);
    base_w = word_cnt;
    base_f = frame_cnt;
    base_p = par_cnt;
    base_o = ovr_cnt;
  endtask

  initial begin
    rst                 = 1'b1;
    uart_rxd            = 1'b1;
    uart_mode           = 2'b00;
    rd_if.uart_rd_ready = 1'b0;
    wait_cyc(4);

    check("rst_valid",     32'(rd_if.uart_rd_valid), 32'd0);
    check("rst_data",      32'(rd_if.uart_rd_data),  32'd0);
    check("rst_busy",      32'(rx_busy),             32'd0);
    check("rst_frame_err", 32'(rx_frame_err),        32'd0);
    check("rst_par_err",   32'(rx_parity_err),       32'd0);
    check("rst_overrun",   32'(rx_overrun),          32'd0);

    rst = 1'b0;
    wait_cyc(20);
    check("idle_busy", 32'(rx_busy), 32'd0);

    // Basic receive, mode 00.
    rd_if.uart_rd_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1);
    wait_cyc(50);
    check_scenario("basic", 1, 0, 0, 0);

    // Even parity: 0x03 has two ones, so parity bit 0 is correct and 1 is wrong.
    uart_mode = 2'b01;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0, 1);
    wait_cyc(50);
    check_scenario("par_ok", 1, 0, 0, 0);
    send_frame(8'h03, 1'b1, 1'b1, 1);
    wait_cyc(50);
    check_scenario("par_bad", 0, 0, 1, 0);

    // Break: line low for 20 bit periods.
    uart_mode = 2'b00;
    uart_rxd  = 1'b0;
    wait_cyc(10 * BIT_CYC);
    check("break_busy_mid", 32'(rx_busy), 32'd1);
    wait_cyc(10 * BIT_CYC);
    check("break_busy_end", 32'(rx_busy), 32'd1);
    uart_rxd = 1'b1;
    wait_cyc(10);
    check("break_busy_released", 32'(rx_busy), 32'd0);
    check_scenario("break", 0, 1, 0, 0);

    // False start: 300-cycle glitch, shorter than the half-bit start check.
    uart_rxd = 1'b0;
    wait_cyc(150);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    wait_cyc(150);
    uart_rxd = 1'b1;
    wait_cyc(BIT_CYC);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check_scenario("false_start", 0, 0, 0, 0);

    // Overrun with the consumer stalled.
    rd_if.uart_rd_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0, 1);
    end
    wait_cyc(50);
    check("ovr_head_data", 32'(rd_if.uart_rd_data), 32'h00);
    rd_if.uart_rd_ready = 1'b1;
    wait_cyc(40);
    check_scenario("overrun", 16, 0, 0, 1);
`else
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1);
    wait_cyc(50);
    check("ovr_hold_valid", 32'(rd_if.uart_rd_valid), 32'd1);
    check("ovr_hold_data",  32'(rd_if.uart_rd_data),  32'h11);
    rd_if.uart_rd_ready = 1'b1;
    wait_cyc(10);
    check_scenario("overrun", 1, 0, 0, 1);
`endif

    // Reset in the middle of bit 4 of 0x5A; the sender abandons that frame too.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h5A >> i) & 8'h01));
    uart_rxd = 1'b1;
    wait_cyc(BIT_CYC / 2);
    rst = 1'b1;
    wait_cyc(5);
    check("midrst_busy",  32'(rx_busy),             32'd0);
    check("midrst_valid", 32'(rd_if.uart_rd_valid), 32'd0);
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(BIT_CYC);
    check("post_rst_busy", 32'(rx_busy), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    wait_cyc(50);
    check_scenario("reset_mid", 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
